// File: rtl/id_gen_if.sv
// Symbol-stream interface for the ID generator: body symbols in, checked ID stream out.
interface id_gen_if;
  logic       in_valid;
  logic [5:0] in_sym;
  logic       out_valid;
  logic [5:0] out_id;
  logic       out_err;
  logic       busy;

  modport master (
    output in_valid, in_sym,
    input  out_valid, out_id, out_err, busy
  );

  modport slave (
    input  in_valid, in_sym,
    output out_valid, out_id, out_err, busy
  );
endinterface

// File: rtl/id_gen.sv
// Collects a 9-symbol ID body (letter + 8 digits), validates it and streams it
// back out with a mod-10 check digit appended.
module id_gen (
  input  logic   clk,
  input  logic   rst_n,
  id_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2} state_t;

  state_t     state_r;
  logic [3:0] cnt_r;
  logic [5:0] buf_r [9];
  logic [3:0] pre_r;
  logic [3:0] acc_r;
  logic [3:0] chk_r;
  logic       err_r;
  logic       out_valid_r;
  logic [5:0] out_id_r;
  logic       out_err_r;
  logic       busy_r;

  logic       letter_ok_s;
  logic       digit_ok_s;
  logic [3:0] pre_nxt_s;
  logic [3:0] acc_nxt_s;
  logic [3:0] chk_s;

  function automatic logic [3:0] add10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd10) begin
      s = s - 5'd10;
    end else begin
      s = s;
    end
    return s[3:0];
  endfunction

  function automatic logic [3:0] neg10(input logic [3:0] a);
    return (a == 4'd0) ? 4'd0 : (4'd10 - a);
  endfunction

  // Letter weight is tens*1 + units*9, and units*9 == -units (mod 10)
  function automatic logic [3:0] letter_lead(input logic [5:0] l);
    logic [3:0] t;
    logic [3:0] u;
    if (l >= 6'd30) begin
      t = 4'd3; u = 4'(l - 6'd30);
    end else if (l >= 6'd20) begin
      t = 4'd2; u = 4'(l - 6'd20);
    end else if (l >= 6'd10) begin
      t = 4'd1; u = 4'(l - 6'd10);
    end else begin
      t = 4'd0; u = 4'd0;
    end
    return add10(t, neg10(u));
  endfunction

  // Descending weights 8..1 equal the sum of running prefix sums of the digits
  always_comb begin
    letter_ok_s = (bus.in_sym >= 6'd10) && (bus.in_sym <= 6'd35);
    digit_ok_s  = (bus.in_sym <= 6'd9);
    pre_nxt_s   = add10(pre_r, digit_ok_s ? bus.in_sym[3:0] : 4'd0);
    acc_nxt_s   = add10(acc_r, pre_nxt_s);
    chk_s       = neg10(acc_nxt_s);
  end

  // Control FSM, symbol buffer, running check sum and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      pre_r       <= 4'd0;
      acc_r       <= 4'd0;
      chk_r       <= 4'd0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_id_r    <= 6'd0;
      out_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        buf_r[i] <= 6'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          out_id_r    <= 6'd0;
          out_err_r   <= 1'b0;
          if (bus.in_valid) begin
            buf_r[0] <= bus.in_sym;
            cnt_r    <= 4'd1;
            pre_r    <= 4'd0;
            acc_r    <= letter_ok_s ? letter_lead(bus.in_sym) : 4'd0;
            err_r    <= !letter_ok_s;
            busy_r   <= 1'b1;
            state_r  <= LOAD;
          end else begin
            busy_r   <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            buf_r[cnt_r] <= bus.in_sym;
            pre_r        <= pre_nxt_s;
            acc_r        <= acc_nxt_s;
            err_r        <= err_r | !digit_ok_s;
            state_r      <= (cnt_r == 4'd8) ? SEND : LOAD;
            if (cnt_r != 4'd8) begin
              cnt_r <= cnt_r + 4'd1;
            end else if (err_r || !digit_ok_s) begin
              out_err_r <= 1'b1;
            end else begin
              out_valid_r <= 1'b1;
              out_id_r    <= buf_r[0];
              chk_r       <= chk_s;
              cnt_r       <= 4'd1;
            end
          end else begin
            cnt_r   <= 4'd0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SEND: begin
          if (out_err_r || (cnt_r == 4'd10)) begin
            out_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
            out_id_r    <= 6'd0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            cnt_r       <= 4'd0;
            state_r     <= IDLE;
          end else if (cnt_r == 4'd9) begin
            out_id_r <= {2'b00, chk_r};
            cnt_r    <= 4'd10;
          end else begin
            out_id_r <= buf_r[cnt_r];
            cnt_r    <= cnt_r + 4'd1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          out_id_r    <= 6'd0;
          out_err_r   <= 1'b0;
          busy_r      <= 1'b0;
          cnt_r       <= 4'd0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_id    = out_id_r;
  assign bus.out_err   = out_err_r;
  assign bus.busy      = busy_r;

endmodule

// File: doc/id_gen.md
ID_GEN -- requirements
Module: id_gen

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low; clock clk.
REQ-003 SHALL have port in_valid  input  1  high while in_sym carries a body symbol.
REQ-004 SHALL have port in_sym  input  6  body symbol: 1st = letter code 10..35, then 8 digits 0..9.
REQ-005 SHALL have port out_valid  output  1  high for exactly 10 consecutive cycles per emitted ID.
REQ-006 SHALL have port out_id  output  6  emitted symbol: letter code, d1..d8, check digit.
REQ-007 SHALL have port out_err  output  1  one-cycle pulse for a rejected body.
REQ-008 SHALL have port busy  output  1  high from 1st accepted symbol until the last out_valid cycle or out_err pulse.

Function
REQ-009 SHALL implement states IDLE, LOAD, SEND.
REQ-010 IDLE: in_valid=1 at an edge SHALL capture in_sym as the letter, set symbol count to 1, and go to LOAD.
REQ-011 LOAD: each edge with in_valid=1 SHALL capture in_sym as the next digit into a 9-entry buffer.
REQ-012 LOAD: in_valid=0 before 9 symbols are captured SHALL abort to IDLE, discard the buffer, emit nothing, and pulse no out_err.
REQ-013 Weighted sum, mod 10: letter L contributes (L/10)*1 + (L%10)*9; digits d1..d8 use weights 8,7,6,5,4,3,2,1.
REQ-014 Sum SHALL accumulate incrementally as a 4-bit mod-10 value, with no wide adder or divider.
REQ-015 Check digit SHALL be (10 - sum) mod 10, so the sum of all 10 symbols under checker weights is 0 mod 10.
REQ-016 Validity: letter outside 10..35 or any digit >9 SHALL set a sticky error flag for the current body.
REQ-017 Edge capturing the 9th symbol with error flag clear SHALL go to SEND; out_valid SHALL rise on the next cycle (1-cycle latency).
REQ-018 SEND SHALL drive out_id = letter, d1..d8, check on 10 consecutive cycles with out_valid=1, no gaps, then return to IDLE.
REQ-019 9th symbol with error flag set SHALL pulse out_err for 1 cycle on the next cycle, emit no stream, and return to IDLE.
REQ-020 in_valid during SEND or on the out_err cycle SHALL be ignored; those symbols are lost.
REQ-021 in_valid=1 on the cycle after return to IDLE SHALL start a new body, giving back-to-back IDs separated by 1 idle cycle.
REQ-022 out_valid=0 SHALL force out_id=0.
REQ-023 in_valid staying high past the 9th symbol SHALL NOT extend LOAD; the 10th cycle falls in SEND and is ignored.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, out_valid=0, out_id=0, out_err=0, busy=0, and clear count, sum, error flag and buffer.
REQ-025 Reset during LOAD or SEND SHALL abandon the ID; no partial stream SHALL resume after release.
REQ-026 First edge after release with in_valid=1 SHALL be treated as a letter.

Verification
REQ-027 Body 10,1,2,3,4,5,6,7,8 -> out_id 10,1,2,3,4,5,6,7,8,9 over 10 cycles, out_valid rising 1 cycle after the 9th input.
REQ-028 Body 11,0,0,0,0,0,0,0,0 -> check 0; body 35,9,9,9,9,9,9,9,9 -> check 8.
REQ-029 Body 36,1,1,1,1,1,1,1,1 or digit 12 in d5 -> single out_err pulse, out_valid stays 0, busy falls after the pulse.
REQ-030 in_valid drops after 5 symbols -> no output, no out_err, busy=0 next cycle; next full body is emitted correctly.
REQ-031 rst_n pulsed at the 4th SEND cycle -> out_valid=0 at once and stays 0 after release; next body emits normally.
REQ-032 Two bodies with a 1-cycle gap, plus in_valid held high during SEND -> both IDs emitted intact; SEND-time input is ignored; every stream is accepted by the team's ID checker.
